width_16to24: RTL and testbench

Gearbox stage directly downstream of the 8-to-16 width converter: accepts 16-bit words and repacks them MSB-first into 24-bit words, so three input words become two output words. A flush request drains a partial residue as a zero-padded, byte-counted word. There is no backpressure in either direction; input rate is at most one word per cycle.

---
 rtl/width_pkg.sv | 15 +
 rtl/width_16to24.sv | 109 ++++++++++
 tb/tb_width_16to24.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/width_pkg.sv
// Shared definitions for the byte-stream width converters.
package width_pkg;

  // Number of bytes currently held in the residue register.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_e;

  localparam logic [1:0] BYTES_1 = 2'd1;
  localparam logic [1:0] BYTES_2 = 2'd2;
  localparam logic [1:0] BYTES_3 = 2'd3;

endpackage

// File: rtl/width_16to24.sv
// 16-bit to 24-bit gearbox: repacks an MSB-first byte stream, three input
// words per two output words, with a flush that drains a zero-padded residue.
module width_16to24
  import width_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  input  logic        flush,
  output logic        valid_out,
  output logic [23:0] data_out,
  output logic [1:0]  bytes_out
);

  state_e      r_state;
  logic [15:0] r_res;
  logic        r_pend;
  logic        r_vld;
  logic [23:0] r_data;
  logic [1:0]  r_bytes;

  state_e      w_nxt_state;
  logic [15:0] w_nxt_res;
  logic        w_nxt_pend;
  logic        w_nxt_vld;
  logic [23:0] w_nxt_data;
  logic [1:0]  w_nxt_bytes;
  logic        w_flush;

  // A flush that lands while a full word is being emitted from S2 leaves one
  // byte behind; r_pend carries the request over so that byte drains next.
  assign w_flush = flush | r_pend;

  // Next-state and emit decode.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_res   = r_res;
    w_nxt_pend  = 1'b0;
    w_nxt_vld   = 1'b0;
    w_nxt_data  = r_data;
    w_nxt_bytes = r_bytes;
    case (r_state)
      S0: begin
        if (valid_in && w_flush) begin
          w_nxt_vld   = 1'b1;
          w_nxt_data  = {data_in, 8'h00};
          w_nxt_bytes = BYTES_2;
        end else if (valid_in) begin
          w_nxt_res   = data_in;
          w_nxt_state = S2;
        end
      end
      S2: begin
        if (valid_in) begin
          w_nxt_vld        = 1'b1;
          w_nxt_data       = {r_res, data_in[15:8]};
          w_nxt_bytes      = BYTES_3;
          w_nxt_res[15:8]  = data_in[7:0];
          w_nxt_state      = S1;
          w_nxt_pend       = w_flush;
        end else if (w_flush) begin
          w_nxt_vld   = 1'b1;
          w_nxt_data  = {r_res, 8'h00};
          w_nxt_bytes = BYTES_2;
          w_nxt_state = S0;
        end
      end
      S1: begin
        if (valid_in) begin
          w_nxt_vld   = 1'b1;
          w_nxt_data  = {r_res[15:8], data_in};
          w_nxt_bytes = BYTES_3;
          w_nxt_state = S0;
        end else if (w_flush) begin
          w_nxt_vld   = 1'b1;
          w_nxt_data  = {r_res[15:8], 16'h0000};
          w_nxt_bytes = BYTES_1;
          w_nxt_state = S0;
        end
      end
      default: w_nxt_state = S0;
    endcase
  end

  // State, residue and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S0;
      r_res   <= 16'h0;
      r_pend  <= 1'b0;
      r_vld   <= 1'b0;
      r_data  <= 24'h0;
      r_bytes <= 2'd0;
    end else begin
      r_state <= w_nxt_state;
      r_res   <= w_nxt_res;
      r_pend  <= w_nxt_pend;
      r_vld   <= w_nxt_vld;
      r_data  <= w_nxt_data;
      r_bytes <= w_nxt_bytes;
    end
  end

  assign valid_out = r_vld;
  assign data_out  = r_data;
  assign bytes_out = r_bytes;

endmodule

// File: tb/tb_width_16to24.sv
// Self-checking bench for width_16to24: directed scenarios with literal
// expectations, then random traffic against a byte-queue reference model.
module tb_width_16to24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        flush = 1'b0;
  logic        valid_out;
  logic [23:0] data_out;
  logic [1:0]  bytes_out;

  int checks = 0;
  int errors = 0;

  width_16to24 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .flush(flush), .valid_out(valid_out), .data_out(data_out),
    .bytes_out(bytes_out)
  );

  always #5 clk = ~clk;

  // Directed stimulus row: inputs for one cycle, expected outputs after it.
  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        f;
    logic        ev;
    logic [23:0] ed;
    logic [1:0]  eb;
  } row_t;

  // Apply one cycle of inputs; return #1 after the edge that sampled them.
  task automatic drive(input logic v, input logic [15:0] d, input logic f);
    valid_in = v; data_in = d; flush = f;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_rows(input string name, input row_t rows[$]);
    foreach (rows[i]) begin
      drive(rows[i].v, rows[i].d, rows[i].f);
      checks++;
      if (valid_out !== rows[i].ev || data_out !== rows[i].ed || bytes_out !== rows[i].eb) begin
        errors++;
        $display("FAIL %s step %0d: got v=%b d=%h b=%0d, want v=%b d=%h b=%0d",
                 name, i, valid_out, data_out, bytes_out, rows[i].ev, rows[i].ed, rows[i].eb);
      end
    end
  endtask

  task automatic test_reset();
    valid_in = 1'b1; data_in = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 24'h0 || bytes_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h b=%0d, want 0/000000/0", valid_out, data_out, bytes_out);
    end
    valid_in = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    row_t r[$];
    do_reset();
    r = '{'{1,16'h0102,0, 0,24'h0,0},
          '{1,16'h0304,0, 1,24'h010203,3},
          '{1,16'h0506,0, 1,24'h040506,3},
          '{0,16'h0000,0, 0,24'h040506,3}};
    run_rows("stream", r);
  endtask

  task automatic test_idle_cadence();
    row_t r[$];
    do_reset();
    r = '{'{1,16'h0102,0, 0,24'h0,0},
          '{0,16'h0000,0, 0,24'h0,0},
          '{1,16'h0304,0, 1,24'h010203,3},
          '{0,16'h0000,0, 0,24'h010203,3},
          '{1,16'h0506,0, 1,24'h040506,3},
          '{0,16'h0000,0, 0,24'h040506,3}};
    run_rows("idle_cadence", r);
  endtask

  task automatic test_flush_alone();
    row_t r[$];
    do_reset();
    r = '{'{1,16'hAABB,0, 0,24'h0,0},
          '{0,16'h0000,1, 1,24'hAABB00,2},
          '{1,16'h1122,0, 0,24'hAABB00,2},
          '{0,16'h0000,0, 0,24'hAABB00,2},
          '{1,16'h3344,0, 1,24'h112233,3}};
    run_rows("flush_alone", r);
  endtask

  task automatic test_flush_coincident();
    row_t r[$];
    do_reset();
    r = '{'{1,16'hAABB,0, 0,24'h0,0},
          '{1,16'hCCDD,1, 1,24'hAABBCC,3},
          '{0,16'h0000,0, 1,24'hDD0000,1},
          '{0,16'h0000,1, 0,24'hDD0000,1},
          '{0,16'h0000,0, 0,24'hDD0000,1}};
    run_rows("flush_coincident", r);
  endtask

  task automatic test_flush_pend();
    row_t r[$];
    do_reset();
    r = '{'{1,16'h0102,0, 0,24'h0,0},
          '{1,16'h0304,1, 1,24'h010203,3},
          '{1,16'h0506,0, 1,24'h040506,3},
          '{1,16'h0708,0, 0,24'h040506,3},
          '{0,16'h0000,1, 1,24'h070800,2}};
    run_rows("flush_pend", r);
  endtask

  task automatic test_reset_midword();
    row_t r[$];
    do_reset();
    drive(1, 16'h0102, 0);
    drive(1, 16'h0304, 0);
    valid_in = 1'b1; data_in = 16'h0102;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 24'h0 || bytes_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h b=%0d, want 0/000000/0", valid_out, data_out, bytes_out);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst = 1'b0;
    r = '{'{1,16'h0304,0, 0,24'h0,0},
          '{1,16'h0506,0, 1,24'h030405,3},
          '{0,16'h0000,0, 0,24'h030405,3}};
    run_rows("reset_midword", r);
  endtask

  // Random traffic checked against a byte queue: bytes enter in stream
  // order, any three leave as a full word, and a flush drains what is left
  // (deferred one cycle if a full word already went out this cycle).
  task automatic test_random();
    logic [7:0]  q[$];
    bit          pend = 0;
    logic        ev;
    logic [23:0] ed = 24'h0;
    logic [1:0]  eb = 2'd0;
    logic        v, f, eff;
    logic [15:0] d;
    int          n;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) < 2);
      d = 16'($urandom);
      drive(v, d, f);
      ev = 1'b0;
      if (v) begin q.push_back(d[15:8]); q.push_back(d[7:0]); end
      eff = f | pend;
      pend = 0;
      if (q.size() >= 3) begin
        ev = 1'b1; ed = {q[0], q[1], q[2]}; eb = 2'd3;
        repeat (3) void'(q.pop_front());
      end
      if (eff && q.size() > 0) begin
        if (ev) pend = 1;
        else begin
          n = q.size();
          ed = 24'h0;
          for (int k = 0; k < n; k++) ed[23-8*k -: 8] = q[k];
          ev = 1'b1; eb = 2'(n);
          q.delete();
        end
      end
      checks++;
      if (valid_out !== ev || data_out !== ed || bytes_out !== eb) begin
        errors++;
        $display("FAIL random cycle %0d: got v=%b d=%h b=%0d, want v=%b d=%h b=%0d",
                 c, valid_out, data_out, bytes_out, ev, ed, eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_idle_cadence();
    test_flush_alone();
    test_flush_coincident();
    test_flush_pend();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
